// File: rtl/excp_ctrl_pkg.sv
// Shared exception codes, FSM encoding and encoder types for the WB-stage
// exception/ertn commit controller.
package excp_ctrl_pkg;

    localparam logic [5:0] ECODE_INT = 6'h00;
    localparam logic [5:0] ECODE_ADE = 6'h08;
    localparam logic [5:0] ECODE_ALE = 6'h09;
    localparam logic [5:0] ECODE_SYS = 6'h0B;
    localparam logic [5:0] ECODE_BRK = 6'h0C;
    localparam logic [5:0] ECODE_INE = 6'h0D;

    localparam logic [2:0] ESUBCODE_ADEF = 3'd0;

    // Bit positions inside ws_excp = {ALE, BRK, SYS, INE, ADEF}
    localparam int EXCP_ADEF = 0;
    localparam int EXCP_INE  = 1;
    localparam int EXCP_SYS  = 2;
    localparam int EXCP_BRK  = 3;
    localparam int EXCP_ALE  = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FLUSH,
        ST_DRAIN,
        ST_REDIRECT
    } excp_state_e;

    typedef enum logic [1:0] {
        BADV_NONE,
        BADV_PC,
        BADV_VADDR
    } badv_sel_e;

endpackage

// File: rtl/excp_ctrl_if.sv
// Fetch redirect handshake between the exception controller and the IF stage.
interface excp_ctrl_if;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ready;

    modport master (output redirect_valid, output redirect_pc, input redirect_ready);
    modport slave  (input redirect_valid, input redirect_pc, output redirect_ready);
endinterface

// File: rtl/excp_ctrl_prio_enc.sv
// Combinational priority pick among interrupt, WB exception flags and ertn.
module excp_prio_enc
    import excp_ctrl_pkg::*;
(
    input  logic       has_int,
    input  logic [4:0] ws_excp,
    input  logic       ws_ertn,
    output logic       take,
    output logic       is_ertn,
    output logic [5:0] ecode,
    output logic [2:0] esubcode,
    output badv_sel_e  badv_sel
);

    always_comb begin
        take     = 1'b1;
        is_ertn  = 1'b0;
        ecode    = ECODE_INT;
        esubcode = 3'd0;
        badv_sel = BADV_NONE;
        if (has_int) begin
            ecode = ECODE_INT;
        end else if (ws_excp[EXCP_ADEF]) begin
            ecode    = ECODE_ADE;
            esubcode = ESUBCODE_ADEF;
            badv_sel = BADV_PC;
        end else if (ws_excp[EXCP_INE]) begin
            ecode = ECODE_INE;
        end else if (ws_excp[EXCP_SYS]) begin
            ecode = ECODE_SYS;
        end else if (ws_excp[EXCP_BRK]) begin
            ecode = ECODE_BRK;
        end else if (ws_excp[EXCP_ALE]) begin
            ecode    = ECODE_ALE;
            badv_sel = BADV_VADDR;
        end else if (ws_ertn) begin
            is_ertn = 1'b1;
        end else begin
            take = 1'b0;
        end
    end

endmodule

// File: rtl/excp_ctrl.sv
// Exception/ertn commit controller: captures the WB event, pulses the CSR
// flush, drains memory, then redirects fetch to eentry or era.
module excp_ctrl
    import excp_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               ws_valid,
    input  logic [31:0]        ws_pc,
    input  logic [4:0]         ws_excp,
    input  logic               ws_ertn,
    input  logic [31:0]        ws_vaddr,
    input  logic               has_int,
    input  logic [31:0]        csr_era,
    input  logic [31:0]        csr_eentry,
    input  logic               mem_outstanding,
    excp_ctrl_if.master        redir,
    output logic               ws_cancel,
    output logic               excp_flush,
    output logic               ertn_flush,
    output logic [5:0]         ecode,
    output logic [2:0]         esubcode,
    output logic [31:0]        epc,
    output logic               badv_we,
    output logic [31:0]        badv,
    output logic               pipe_flush,
    output logic               ws_block
);

    excp_state_e state_reg, state_next;

    logic [5:0]  ecode_reg;
    logic [2:0]  esubcode_reg;
    logic [31:0] epc_reg;
    logic [31:0] badv_reg;
    logic        badv_we_reg;
    logic        is_ertn_reg;

    logic        enc_take;
    logic        enc_is_ertn;
    logic [5:0]  enc_ecode;
    logic [2:0]  enc_esubcode;
    badv_sel_e   enc_badv_sel;
    logic [31:0] badv_src;
    logic        take_now;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    excp_prio_enc u_prio_enc (
        .has_int  (has_int),
        .ws_excp  (ws_excp),
        .ws_ertn  (ws_ertn),
        .take     (enc_take),
        .is_ertn  (enc_is_ertn),
        .ecode    (enc_ecode),
        .esubcode (enc_esubcode),
        .badv_sel (enc_badv_sel)
    );

    // Gated by reset so ws_cancel is quiet while the controller is being reset.
    assign take_now = (state_reg == ST_IDLE) && ws_valid && enc_take && !reset;

    always_comb begin
        case (enc_badv_sel)
            BADV_PC:    badv_src = ws_pc;
            BADV_VADDR: badv_src = ws_vaddr;
            default:    badv_src = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            ecode_reg    <= 6'd0;
            esubcode_reg <= 3'd0;
            epc_reg      <= 32'd0;
            badv_reg     <= 32'd0;
            badv_we_reg  <= 1'b0;
            is_ertn_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (take_now) begin
                ecode_reg    <= enc_ecode;
                esubcode_reg <= enc_esubcode;
                epc_reg      <= ws_pc;
                badv_reg     <= badv_src;
                badv_we_reg  <= (enc_badv_sel != BADV_NONE);
                is_ertn_reg  <= enc_is_ertn;
            end
        end
    end

    always_comb begin
        state_next     = state_reg;
        ws_cancel      = 1'b0;
        excp_flush     = 1'b0;
        ertn_flush     = 1'b0;
        badv_we        = 1'b0;
        pipe_flush     = 1'b0;
        ws_block       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        case (state_reg)
            ST_IDLE: begin
                ws_cancel = take_now;
                if (take_now) state_next = ST_FLUSH;
            end
            ST_FLUSH: begin
                excp_flush = !is_ertn_reg;
                ertn_flush = is_ertn_reg;
                badv_we    = badv_we_reg;
                pipe_flush = 1'b1;
                ws_block   = 1'b1;
                state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                pipe_flush = 1'b1;
                ws_block   = 1'b1;
                if (!mem_outstanding) state_next = ST_REDIRECT;
            end
            ST_REDIRECT: begin
                pipe_flush     = 1'b1;
                ws_block       = 1'b1;
                redirect_valid = 1'b1;
                // CSRs were written at the end of FLUSH, so the live value is current.
                redirect_pc    = is_ertn_reg ? csr_era : csr_eentry;
                if (redir.redirect_ready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign redir.redirect_valid = redirect_valid;
    assign redir.redirect_pc    = redirect_pc;
    assign ecode                = ecode_reg;
    assign esubcode             = esubcode_reg;
    assign epc                  = epc_reg;
    assign badv                 = badv_reg;

endmodule
